// File: rtl/pipeline_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stage_buffer
// Description : Pipeline stage register with valid/ready handshake, kill and
//               flush handling, and an unstalled sideband register.
//               A main register drives out_data; when PIPE_STAGE_SKID_EN is
//               defined a skid register holds a second beat so that in_ready
//               comes straight from state flops. When the macro is undefined
//               the stage holds one beat and in_ready looks at out_ready.
// Macro       : PIPE_STAGE_SKID_EN (two-entry skid buffer enable)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stage_buffer #(
  parameter int                DATA_W   = 128,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}},
  parameter int                SIDE_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_kill,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic [SIDE_W-1:0] side_in,
  output logic [SIDE_W-1:0] q_side,
  output logic [1:0]        occ
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [SIDE_W-1:0] r_side;
  logic              w_accept;
  logic              w_store;
  logic              w_pop;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] r_skid;
`endif

  // Handshake qualifiers: a killed beat is accepted but never stored.
  always_comb begin
    w_accept = in_valid & in_ready & ~flush;
    w_store  = w_accept & ~in_kill;
    w_pop    = out_valid & out_ready;
  end

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; flush discards everything, ignoring accept and pop.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = c_EMPTY;
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (w_store) w_state_nxt = c_ONE;
        end
        c_ONE: begin
`ifdef PIPE_STAGE_SKID_EN
          if (w_store && !w_pop) w_state_nxt = c_FULL;
          else if (!w_store && w_pop) w_state_nxt = c_EMPTY;
`else
          if (!w_store && w_pop) w_state_nxt = c_EMPTY;
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        c_FULL: begin
          if (w_pop) w_state_nxt = c_ONE;
        end
`endif
        default: w_state_nxt = c_EMPTY;
      endcase
    end
  end

  // Output decode; out_data is forced to the NOP encoding whenever idle.
  always_comb begin
    occ       = r_state;
    out_valid = (r_state != c_EMPTY);
    out_data  = (r_state != c_EMPTY) ? r_main : NOP_WORD;
`ifdef PIPE_STAGE_SKID_EN
    // Registered-only decode keeps out_ready off the upstream ready path.
    in_ready  = (r_state != c_FULL);
`else
    in_ready  = (r_state == c_EMPTY) | out_ready;
`endif
    q_side    = r_side;
  end

  // Payload registers: main feeds the output, skid catches the overflow beat.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_main <= NOP_WORD;
`ifdef PIPE_STAGE_SKID_EN
      r_skid <= NOP_WORD;
`endif
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (w_store) r_main <= in_data;
        end
        c_ONE: begin
          if (w_store && w_pop) r_main <= in_data;
`ifdef PIPE_STAGE_SKID_EN
          else if (w_store) r_skid <= in_data;
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        c_FULL: begin
          if (w_pop) begin
            r_main <= r_skid;
            r_skid <= NOP_WORD;
          end
        end
`endif
        default: r_main <= r_main;
      endcase
    end
  end

  // Sideband follows side_in every cycle regardless of stall, kill or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_side <= '0;
    end else begin
      r_side <= side_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stage_buffer
// Description : Self-checking bench for pipeline_stage_buffer. A queue-based
//               reference model tracks the held beats; directed scenarios are
//               followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_buffer;

  localparam int          DW  = 32;
  localparam int          SW  = 2;
  localparam logic [31:0] NOP = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_SKID_EN
  localparam int          CAP = 2;
`else
  localparam int          CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_kill;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] side_in;
  logic [SW-1:0] q_side;
  logic [1:0]    occ;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [SW-1:0] mside;

  pipeline_stage_buffer #(
    .DATA_W   (DW),
    .NOP_WORD (NOP),
    .SIDE_W   (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_kill   (in_kill),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .side_in   (side_in),
    .q_side    (q_side),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare outputs against the model, then advance
  // the model with the same rules the stage must obey at the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic k,
                      input logic f, input logic r, input logic [SW-1:0] s,
                      input logic rs);
    logic exp_rdy;
    logic acc;
    logic pop;
    in_valid  = v;
    in_data   = d;
    in_kill   = k;
    flush     = f;
    out_ready = r;
    side_in   = s;
    rst       = rs;
    #1;
    exp_rdy = (CAP == 2) ? (mq.size() < 2) : ((mq.size() == 0) || r);
    check("occ",       32'(occ),       32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("out_data",  out_data,       (mq.size() != 0) ? mq[0] : NOP);
    check("in_ready",  32'(in_ready),  32'(exp_rdy));
    check("q_side",    32'(q_side),    32'(mside));
    @(posedge clk);
    if (rs) begin
      mq.delete();
      mside = '0;
    end else begin
      mside = s;
      if (f) begin
        mq.delete();
      end else begin
        acc = v && exp_rdy;
        pop = (mq.size() != 0) && r;
        if (pop) void'(mq.pop_front());
        if (acc && !k) mq.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_kill = 1'b0;
    flush = 1'b0; out_ready = 1'b0; side_in = '0;
    @(posedge clk);
    #1;
    mq.delete();
    mside = '0;

    // Single beat latency with out_ready high
    step(1, 32'hA5, 0, 0, 1, 2'd0, 0);
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);

    // Back-pressure: two beats stall, then drain in order
    step(1, 32'h11, 0, 0, 0, 2'd0, 0);
    step(1, 32'h22, 0, 0, 0, 2'd0, 0);
    step(0, 32'h00, 0, 0, 0, 2'd0, 0);
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);

    // Killed beat is consumed but never emitted
    step(1, 32'h33, 1, 0, 1, 2'd0, 0);
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);

    // Flush while full with a concurrent incoming beat
    step(1, 32'h44, 0, 0, 0, 2'd0, 0);
    step(1, 32'h55, 0, 0, 0, 2'd0, 0);
    step(1, 32'h66, 0, 1, 0, 2'd0, 0);
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);

    // Sideband toggling through a stall and a flush
    step(1, 32'h77, 0, 0, 0, 2'd0, 0);
    step(1, 32'h88, 0, 0, 0, 2'd1, 0);
    step(1, 32'h99, 0, 0, 0, 2'd0, 0);
    step(0, 32'h00, 0, 1, 0, 2'd1, 0);
    step(0, 32'h00, 0, 1, 0, 2'd0, 0);
    step(0, 32'h00, 0, 0, 1, 2'd3, 0);

    // Reset while full, with flush/accept/pop also asserted
    step(1, 32'hAA, 0, 0, 0, 2'd2, 0);
    step(1, 32'hBB, 0, 0, 0, 2'd1, 0);
    step(1, 32'hCC, 0, 1, 1, 2'd3, 1);
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);
    step(1, 32'hDD, 0, 0, 1, 2'd1, 0);
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 8) == 0,
           ($urandom % 16) == 0, ($urandom % 3) != 0,
           SW'($urandom), ($urandom % 64) == 0);
    end
    step(0, 32'h00, 0, 0, 1, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
